// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between the requesting masters and the weighted
// round-robin arbiter. The master side drives requests and weights; the
// slave side (the arbiter) returns the registered grant.
interface wrr_arbiter_if #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 3,
  parameter int ID_W     = $clog2(N)
);
  logic [N-1:0]          Req;
  logic [N*WEIGHT_W-1:0] Weight;
  logic [N-1:0]          Grant;
  logic [ID_W-1:0]       Grant_Id;
  logic                  Grant_Valid;

  modport master (
    output Req,
    output Weight,
    input  Grant,
    input  Grant_Id,
    input  Grant_Valid
  );

  modport slave (
    input  Req,
    input  Weight,
    output Grant,
    output Grant_Id,
    output Grant_Valid
  );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter. Grants one of N requesters at a time with a
// registered one-hot grant; a grantee keeps the grant for up to its latched
// weight in consecutive cycles (weight 0 counts as 1), then the search
// resumes just past it. Dropping the request mid-burst forfeits the rest.
module wrr_arbiter #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 3,
  parameter int ID_W     = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst_n,
  wrr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [N-1:0]          grant, grant_nxt;
  logic [ID_W-1:0]       cur, cur_nxt;
  logic [ID_W-1:0]       ptr, ptr_nxt;
  logic [WEIGHT_W-1:0]   cnt, cnt_nxt;
  logic [WEIGHT_W-1:0]   wcur, wcur_nxt;
  logic                  hold;
  logic                  found;
  logic [ID_W-1:0]       pick;

  // A zero weight field still buys one cycle of grant.
  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  // Circular search of the request vector starting at start; the lowest
  // offset from start wins.
  function automatic logic [ID_W:0] find_next(input logic [N-1:0] req,
                                              input logic [ID_W-1:0] start);
    logic [ID_W:0] res;
    res = '0;
    for (int s = N - 1; s >= 0; s--) begin
      int idx;
      idx = (int'(start) + s) % N;
      if (req[idx]) begin
        res = {1'b1, ID_W'(idx)};
      end
    end
    return res;
  endfunction

  // Candidate for the next grant start, searched from the rotation pointer.
  always_comb begin
    {found, pick} = find_next(bus.Req, ptr);
  end

  // Next-state decision: hold the burst, rotate/start a new one, or go idle.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cur_nxt   = cur;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    wcur_nxt  = wcur;
    // Widened compare keeps cnt+1 from wrapping at the maximum weight.
    hold = (state == BURST) && bus.Req[cur] &&
           (({1'b0, cnt} + 1'b1) < {1'b0, wcur});
    if (hold) begin
      cnt_nxt = cnt + WEIGHT_W'(1);
    end else if (found) begin
      state_nxt = BURST;
      grant_nxt = {{(N-1){1'b0}}, 1'b1} << pick;
      cur_nxt   = pick;
      cnt_nxt   = '0;
      wcur_nxt  = eff_weight(bus.Weight[pick*WEIGHT_W +: WEIGHT_W]);
      ptr_nxt   = (pick == ID_W'(N - 1)) ? '0 : pick + ID_W'(1);
    end else begin
      state_nxt = IDLE;
      grant_nxt = '0;
      cur_nxt   = '0;
      cnt_nxt   = '0;
    end
  end

  // State, grant and burst bookkeeping registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      cur   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      wcur  <= WEIGHT_W'(1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      cur   <= cur_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      wcur  <= wcur_nxt;
    end
  end

  assign bus.Grant       = grant;
  assign bus.Grant_Id    = cur;
  assign bus.Grant_Valid = |grant;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed sequences with hand-derived grants plus a
// randomized phase against a small reference model, all through a scoreboard.
module tb_wrr_arbiter;
  localparam int N        = 4;
  localparam int WEIGHT_W = 3;
  localparam int ID_W     = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wrr_arbiter_if #(.N(N), .WEIGHT_W(WEIGHT_W), .ID_W(ID_W)) bus ();

  wrr_arbiter #(.N(N), .WEIGHT_W(WEIGHT_W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];

  // reference model state for the random phase
  int m_active, m_c, m_cnt, m_wcur, m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int id_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic compare(input string tag);
    logic [N-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " grant"}, 32'(bus.Grant), 32'(e));
    check({tag, " grant_id"}, 32'(bus.Grant_Id), 32'(id_of(e)));
    check({tag, " grant_valid"}, 32'(bus.Grant_Valid), 32'(e != '0));
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    bus.Weight = {WEIGHT_W'(w3), WEIGHT_W'(w2), WEIGHT_W'(w1), WEIGHT_W'(w0)};
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] exp_grant, input string tag);
    @(negedge clk);
    bus.Req = req;
    exp_q.push_back(exp_grant);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.Req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model(input logic [N-1:0] req, input logic [N*WEIGHT_W-1:0] w,
                       output logic [N-1:0] g);
    int k;
    bit got;
    if (m_active != 0 && req[m_c] && (m_cnt + 1 < m_wcur)) begin
      m_cnt++;
    end else begin
      got = 0;
      for (int s = 0; s < N; s++) begin
        k = (m_ptr + s) % N;
        if (!got && req[k]) begin
          got    = 1;
          m_c    = k;
          m_cnt  = 0;
          m_wcur = int'(w[k*WEIGHT_W +: WEIGHT_W]);
          if (m_wcur == 0) m_wcur = 1;
          m_ptr  = (k + 1) % N;
        end
      end
      m_active = got ? 1 : 0;
      if (!got) begin
        m_c   = 0;
        m_cnt = 0;
      end
    end
    g = (m_active != 0) ? (N'(1) << m_c) : '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] r;
    logic [N*WEIGHT_W-1:0] w;

    bus.Req = '0;
    set_w(1, 1, 1, 1);

    // reset held with all requests asserted
    @(negedge clk);
    rst_n   = 1'b0;
    bus.Req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('0);
      @(posedge clk);
      #1;
      compare("rst_hold");
    end
    @(negedge clk);
    bus.Req = '0;
    rst_n   = 1'b1;
    set_w(4, 1, 1, 1);
    step(4'hF, 4'b0001, "rst_first");
    step(4'hF, 4'b0001, "rst_burst");
    // asynchronous reset in the middle of a burst
    #2;
    rst_n = 1'b0;
    exp_q.push_back('0);
    #1;
    compare("rst_async");
    @(posedge clk);
    @(negedge clk);
    bus.Req = '0;
    rst_n   = 1'b1;
    step(4'hF, 4'b0001, "rst_release");

    // equal weights
    do_reset();
    set_w(1, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(4'hF, 4'b0001 << (i % 4), "equal");

    // weighted pattern R0x3 R1x1 R2x2 R3x1
    do_reset();
    set_w(3, 1, 2, 0);
    for (int rep = 0; rep < 2; rep++) begin
      step(4'hF, 4'b0001, "wrr_r0");
      step(4'hF, 4'b0001, "wrr_r0");
      step(4'hF, 4'b0001, "wrr_r0");
      step(4'hF, 4'b0010, "wrr_r1");
      step(4'hF, 4'b0100, "wrr_r2");
      step(4'hF, 4'b0100, "wrr_r2");
      step(4'hF, 4'b1000, "wrr_r3_w0");
    end

    // early release forfeits remaining credit
    do_reset();
    set_w(4, 1, 1, 1);
    step(4'b0011, 4'b0001, "early_r0");
    step(4'b0011, 4'b0001, "early_r0");
    step(4'b0010, 4'b0010, "early_drop");
    for (int i = 0; i < 4; i++) step(4'b0011, 4'b0001, "early_fresh");
    step(4'b0011, 4'b0010, "early_rot");

    // single requester re-granted with no bubble
    do_reset();
    set_w(1, 1, 2, 1);
    for (int i = 0; i < 10; i++) step(4'b0100, 4'b0100, "single");

    // weight change mid-burst, then idle keeps the pointer
    do_reset();
    set_w(3, 1, 1, 1);
    step(4'b0011, 4'b0001, "wchg_r0");
    set_w(1, 1, 1, 1);
    step(4'b0011, 4'b0001, "wchg_r0_hold");
    step(4'b0011, 4'b0001, "wchg_r0_hold");
    step(4'b0011, 4'b0010, "wchg_r1");
    step(4'b0011, 4'b0001, "wchg_r0_new");
    step(4'b0011, 4'b0010, "wchg_r1b");
    step(4'b0000, 4'b0000, "idle");
    step(4'hF, 4'b0100, "idle_ptr");
    step(4'hF, 4'b1000, "idle_ptr");
    step(4'hF, 4'b0001, "idle_ptr");
    step(4'hF, 4'b0010, "idle_ptr");

    // randomized traffic against the reference model
    do_reset();
    m_active = 0; m_c = 0; m_cnt = 0; m_wcur = 1; m_ptr = 0;
    w = '0;
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) w = (N*WEIGHT_W)'($urandom);
      bus.Weight = w;
      r = N'($urandom | $urandom);
      if ($urandom_range(0, 9) == 0) r = '0;
      model(r, w, g);
      step(r, g, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter; successor to the fixed 4-requester round-robin arbiter.
- Arbitrates N requesters onto one shared resource with a registered one-hot grant.
- Each requester holds the grant for up to a programmable number of consecutive cycles (its weight), then the grant rotates.
- Sits between requesting masters and a shared bus or port; grant is consumed directly as a select.

Parameters:
- N, 4, number of requesters (N >= 2).
- WEIGHT_W, 3, width of each per-requester weight field; maximum burst is 2^WEIGHT_W - 1 cycles.
- ID_W, $clog2(N), width of Grant_Id.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Req  input  N  request vector; bit i is requester i.
- Weight  input  N*WEIGHT_W  per-requester weights; field i is Weight[i*WEIGHT_W +: WEIGHT_W].
- Grant  output  N  registered one-hot grant, or all-zero.
- Grant_Id  output  ID_W  binary index of the granted requester; 0 when Grant is 0.
- Grant_Valid  output  1  OR of Grant.

Behaviour:
- Reset (asynchronous, rst_n low): Grant=0, Grant_Id=0, Grant_Valid=0, pointer ptr=0, burst counter cnt=0, latched weight wcur=1. Reset is effective mid-burst with no other conditions.
- Latency: Grant in cycle t+1 is a function of Req in cycle t and internal state. A requester never receives a grant in cycle t+1 unless its Req bit was high in cycle t.
- Effective weight: Weight field 0 is treated as 1.
- At grant start, the effective weight of the new grantee is latched into wcur. Weight changes mid-burst are ignored until that requester's next grant start.
- State: IDLE (Grant=0) and BURST (Grant one-hot, current grantee c, cnt = cycles already granted minus 1).
- Each rising edge, the next state is chosen as follows:
  - Hold: in BURST, if Req[c]=1 and cnt+1 < wcur, then Grant stays on c and cnt increments.
  - Rotate or start: otherwise, search Req circularly starting at ptr (ptr, ptr+1, ..., wrapping modulo N). The first set bit k becomes the grantee: Grant=1<<k, cnt=0, wcur=eff(Weight[k]), ptr=(k+1) mod N.
  - Idle: if no Req bit is set, Grant=0, Grant_Id=0, cnt=0, and ptr is unchanged.
- Work-conserving: after an expired burst on c, the search starts at c+1 and wraps. If c is the only requester, c is re-granted immediately with cnt=0 and no bubble cycle.
- Early release: if Req[c] drops mid-burst, the grant moves (or goes to 0) in the next cycle. Remaining credit is forfeited.
- Fairness bound: any continuously requesting requester is granted within sum over j≠i of eff(Weight[j]) + 1 cycles.
- Grant is always zero or one-hot, and Grant_Id and Grant_Valid are consistent with Grant in every cycle.
- cnt is WEIGHT_W bits wide and cannot overflow, because cnt < wcur <= 2^WEIGHT_W - 1.

Test Plan:
- Reset: hold rst_n=0 with Req=4'hF for 3 cycles, then assert rst_n=0 asynchronously mid-burst -> Grant=0, Grant_Id=0, Grant_Valid=0 immediately. The first grant after release is 4'b0001.
- Equal weights: Weight all 1, Req=4'hF from cycle 0 -> from cycle 1, Grant = 0001, 0010, 0100, 1000, 0001, ... Each requester gets exactly 1 cycle.
- Weighted: Weights {R0=3, R1=1, R2=2, R3=0}, Req=4'hF -> repeating 7-cycle pattern: R0 x3, R1 x1, R2 x2, R3 x1 (weight 0 acts as 1).
- Early release: Weight0=4, Req=4'b0011; drop Req[0] after Grant[0] has been high 2 cycles -> Grant=0010 in the cycle after the drop. On R0's next turn it gets a fresh full 4-cycle burst.
- Single requester: Req=4'b0100, Weight2=2, held for 10 cycles -> Grant=0100 every cycle from cycle 1 with no gap; cnt cycles 0, 1, 0, 1, ...
- Weight change and idle: change Weight0 from 3 to 1 during R0's first burst -> that burst still lasts 3 cycles and the next R0 burst lasts 1. Then Req=0 -> Grant=0 the next cycle, ptr unchanged, and the next grant follows ptr order.
